// File: rtl/ft_recovery_ctrl_pkg.sv
// rtl/ft_recovery_ctrl_pkg.sv - shared types and helpers for the recovery sequencer
package ft_pkg;

    localparam int ERR_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_COPY,
        ST_DRAIN,
        ST_SHIFT,
        ST_RESUME,
        ST_FAIL
    } recovery_state_e;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/ft_recovery_ctrl_if.sv
// rtl/ft_recovery_ctrl_if.sv - core handshake and register-file copy signals
interface ft_recovery_if
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) ();
    logic                     error_i;
    logic                     halted_i;
    logic                     halt_o;
    logic                     rf_re_o;
    logic [ADDR_WIDTH-1:0]    rf_raddr_o;
    logic [DATA_WIDTH-1:0]    rf_rdata_i;
    logic                     rf_we_o;
    logic [ADDR_WIDTH-1:0]    rf_waddr_o;
    logic [DATA_WIDTH-1:0]    rf_wdata_o;
    logic                     shift_o;
    logic                     resume_o;
    logic                     busy_o;
    logic                     fail_o;
    logic [ERR_CNT_WIDTH-1:0] err_count_o;

    modport slave (
        input  error_i, halted_i, rf_rdata_i,
        output halt_o, rf_re_o, rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output shift_o, resume_o, busy_o, fail_o, err_count_o
    );

    modport master (
        output error_i, halted_i, rf_rdata_i,
        input  halt_o, rf_re_o, rf_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  shift_o, resume_o, busy_o, fail_o, err_count_o
    );
endinterface

// File: rtl/ft_recovery_ctrl_addr_seq.sv
// rtl/ft_recovery_ctrl_addr_seq.sv - read pointer and one-cycle-delayed write address
module ft_addr_seq #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_issue,
    output logic                  o_last,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic [ADDR_WIDTH-1:0] o_waddr
);
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_waddr;

    assign o_last  = &r_ptr;
    assign o_raddr = r_ptr;
    assign o_waddr = r_waddr;

    // ptr parks on all-ones so the drain cycle still writes the last register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr   <= '0;
            r_waddr <= '0;
        end else if (i_start || i_abort) begin
            r_ptr <= '0;
        end else if (i_issue) begin
            r_waddr <= r_ptr;
            if (!o_last) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ft_recovery_ctrl.sv
// rtl/ft_recovery_ctrl.sv - halt, copy golden RF into faulty RF, shift and resume
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    ft_recovery_if.slave bus
);
    localparam int RETRY_WIDTH = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_WIDTH-1:0] C_MAX_RETRY = RETRY_WIDTH'(MAX_RETRY);

    recovery_state_e          r_state;
    logic [RETRY_WIDTH-1:0]   r_retry_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    logic                  w_start;
    logic                  w_abort;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_start = (r_state == ST_HALT) && bus.halted_i;
    assign w_abort = ((r_state == ST_COPY) || (r_state == ST_DRAIN) || (r_state == ST_SHIFT))
                     && bus.error_i;
    assign w_issue = (r_state == ST_COPY) && !bus.error_i;

    ft_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_seq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_start (w_start),
        .i_abort (w_abort),
        .i_issue (w_issue),
        .o_last  (w_last),
        .o_raddr (w_raddr),
        .o_waddr (w_waddr)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_retry_cnt <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.error_i) begin
                        r_state     <= ST_HALT;
                        r_err_count <= sat_inc(r_err_count);
                        r_retry_cnt <= '0;
                    end
                end
                ST_HALT: begin
                    if (bus.halted_i) begin
                        r_state <= ST_COPY;
                    end
                end
                ST_COPY, ST_DRAIN, ST_SHIFT: begin
                    if (bus.error_i) begin
                        if (r_retry_cnt < C_MAX_RETRY) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_state     <= ST_COPY;
                        end else begin
                            r_state <= ST_FAIL;
                        end
                    end else if (r_state == ST_COPY) begin
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (r_state == ST_DRAIN) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_RESUME;
                    end
                end
                ST_RESUME: r_state <= ST_IDLE;
                ST_FAIL:   r_state <= ST_FAIL;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // ptr is only zero on the first copy cycle, when no read data is available yet
    assign w_we    = ((r_state == ST_COPY) && (w_raddr != '0)) || (r_state == ST_DRAIN);
    assign w_rdata = bus.rf_rdata_i;

    assign bus.halt_o      = (r_state == ST_HALT) || (r_state == ST_COPY) || (r_state == ST_DRAIN)
                             || (r_state == ST_SHIFT) || (r_state == ST_FAIL);
    assign bus.rf_re_o     = (r_state == ST_COPY);
    assign bus.rf_raddr_o  = (r_state == ST_COPY) ? w_raddr : '0;
    assign bus.rf_we_o     = w_we && !bus.error_i;
    assign bus.rf_waddr_o  = w_we ? w_waddr : '0;
    assign bus.rf_wdata_o  = w_rdata;
    assign bus.shift_o     = (r_state == ST_SHIFT);
    assign bus.resume_o    = (r_state == ST_RESUME);
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.fail_o      = (r_state == ST_FAIL);
    assign bus.err_count_o = r_err_count;
endmodule
